// File: rtl/exp_pkg.sv
// exp_pkg
// Shared definitions for the iterative exponential unit:
//   - exp_state_e   : controller states (IDLE, LOAD, MULX, MULR, DONE)
//   - MODE_POS/NEG  : function select encodings (e^x / e^-x)
//   - DEFAULT_GUARD : default number of extra internal fraction bits
//   - K_W           : width of the series index register (holds 0..16)
//   - recip_value   : elaboration-time helper producing 1/k in Q0.fracBits
package exp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MULX,
    MULR,
    DONE
  } exp_state_e;

  localparam logic MODE_POS = 1'b0;
  localparam logic MODE_NEG = 1'b1;

  localparam int DEFAULT_GUARD = 4;

  // The index runs 1..TERMS-1 and is incremented once more on exit, so it
  // must be able to hold 16 for the largest supported term count.
  localparam int K_W = 5;

  // 1/k in Q0.fracBits, truncated. 1/1 = 1.0 is not representable in a
  // purely fractional format, so it saturates to the all-ones fraction.
  function automatic logic [63:0] recip_value(input int k, input int fracBits);
    logic [63:0] one;
    one = 64'd1 << fracBits;
    if (k <= 0) begin
      return 64'd0;
    end
    if (k == 1) begin
      return one - 64'd1;
    end
    return one / 64'(k);
  endfunction

endpackage

// File: rtl/exp_recip_rom.sv
// exp_recip_rom
// Constant table of reciprocals used by the series update term *= 1/k.
// Entries 1..TERMS-1 hold 1/k in Q0.(FRAC_W+GUARD); every other index
// returns zero. Purely combinational, indexed directly by the iteration
// counter.
//   k_i     : series index
//   recip_o : 1/k_i in Q0.(FRAC_W+GUARD)
module exp_recip_rom
  import exp_pkg::*;
#(
  parameter int FRAC_W = 16,
  parameter int GUARD  = DEFAULT_GUARD,
  parameter int TERMS  = 8
) (
  input  logic [K_W-1:0]          k_i,
  output logic [FRAC_W+GUARD-1:0] recip_o
);

  localparam int RW      = FRAC_W + GUARD;
  localparam int ENTRIES = 1 << K_W;

  logic [RW-1:0] table_w [0:ENTRIES-1];

  // Table contents are fixed at elaboration; unused slots read as zero so
  // an out-of-range index can never produce a spurious non-zero factor.
  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    if (i >= 1 && i <= TERMS - 1) begin : g_valid
      assign table_w[i] = RW'(recip_value(i, RW));
    end else begin : g_zero
      assign table_w[i] = '0;
    end
  end

  assign recip_o = table_w[k_i];

endmodule

// File: rtl/exponential_param.sv
// exponential_param
// Iterative Taylor-series evaluator for e^x or e^-x with x in [0,1).
// One shared "times x" multiplier and one shared "times 1/k" multiplier
// are reused every iteration; the series
//   acc = sum_{k=0}^{TERMS-1} (+/-1)^k x^k / k!
// is built up two cycles per term (MULX then MULR).
//   clk      : clock, rising-edge
//   rst      : asynchronous active-high reset
//   start    : request strobe, only honoured in IDLE
//   x        : operand, unsigned Q0.FRAC_W
//   mode     : 0 = e^x, 1 = e^-x
//   busy     : high whenever the controller is not in IDLE
//   done     : one-cycle completion pulse
//   intpart  : integer part of the latest result
//   fracpart : fractional part of the latest result (Q0.FRAC_W)
module exponential_param
  import exp_pkg::*;
#(
  parameter int FRAC_W = 16,
  parameter int INT_W  = 2,
  parameter int TERMS  = 8,
  parameter int GUARD  = DEFAULT_GUARD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FRAC_W-1:0] x,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic [INT_W-1:0]  intpart,
  output logic [FRAC_W-1:0] fracpart
);

  // Internal format is Q(INT_W).(FRAC_W+GUARD).
  localparam int W     = INT_W + FRAC_W + GUARD;
  localparam int RW    = FRAC_W + GUARD;
  localparam int PX_W  = W + FRAC_W;
  localparam int PR_W  = W + RW;
  localparam int RES_W = INT_W + FRAC_W;

  localparam logic [W-1:0] ONE = W'(1) << RW;

  exp_state_e        state_q, state_d;
  logic [FRAC_W-1:0] x_q, x_d;
  logic              mode_q, mode_d;
  logic [W-1:0]      term_q, term_d;
  logic [W-1:0]      acc_q, acc_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [RES_W-1:0]  res_q, res_d;

  logic [RW-1:0]     recip;
  logic [PX_W-1:0]   prodX;
  logic [PR_W-1:0]   prodR;
  logic [W-1:0]      termX;
  logic [W-1:0]      termR;
  logic [W:0]        accSum;
  logic [W-1:0]      accStep;
  logic              subtract;

  exp_recip_rom #(
    .FRAC_W (FRAC_W),
    .GUARD  (GUARD),
    .TERMS  (TERMS)
  ) u_recip (
    .k_i     (k_q),
    .recip_o (recip)
  );

  // Shared multipliers. Since x < 1 and 1/k <= 1, neither scaled product
  // can exceed the current term, so the upper bits after the shift always
  // fit in W bits and the term can never leave its saturation range.
  assign prodX = PX_W'(term_q) * PX_W'(x_q);
  assign prodR = PR_W'(term_q) * PR_W'(recip);
  assign termX = W'(prodX >> FRAC_W);
  assign termR = W'(prodR >> RW);

  // Odd-index terms are subtracted only for e^-x.
  assign subtract = (mode_q == MODE_NEG) && k_q[0];

  // Accumulator update for the term produced this MULR cycle: saturating
  // add, or subtract clamped at zero.
  always_comb begin
    accSum = {1'b0, acc_q} + {1'b0, termR};
    if (subtract) begin
      accStep = (termR > acc_q) ? '0 : (acc_q - termR);
    end else begin
      accStep = accSum[W] ? '1 : accSum[W-1:0];
    end
  end

  // Controller next-state and datapath register updates. Operands are
  // captured only on the IDLE->LOAD transition so later changes on x/mode
  // cannot disturb an operation in flight. The result register is written
  // only on the edge that enters DONE, so it holds across new requests.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    mode_d  = mode_q;
    term_d  = term_q;
    acc_d   = acc_q;
    k_d     = k_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = x;
          mode_d  = mode;
          state_d = LOAD;
        end
      end
      LOAD: begin
        acc_d   = ONE;
        term_d  = ONE;
        k_d     = K_W'(1);
        state_d = MULX;
      end
      MULX: begin
        term_d  = termX;
        state_d = MULR;
      end
      MULR: begin
        term_d = termR;
        acc_d  = accStep;
        k_d    = k_q + K_W'(1);
        // Stop after the last configured term, or as soon as the term has
        // underflowed to zero since every later term would be zero too.
        if ((k_q == K_W'(TERMS - 1)) || (termR == '0)) begin
          res_d   = RES_W'(accStep >> GUARD);
          state_d = DONE;
        end else begin
          state_d = MULX;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      mode_q  <= MODE_POS;
      term_q  <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      mode_q  <= mode_d;
      term_q  <= term_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      res_q   <= res_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign {intpart, fracpart} = res_q;

endmodule

// File: tb/tb_exponential_param.sv
// tb_exponential_param
// Directed plus randomized checks of exponential_param at default
// parameters. Results are compared against real-valued e^x / e^-x, and
// the exit index implied by the latency is compared against the point
// where the exact series term x^k/k! drops below one internal LSB.
module tb_exponential_param;

  localparam int FRAC_W = 16;
  localparam int INT_W  = 2;
  localparam int TERMS  = 8;
  localparam int GUARD  = 4;
  localparam int TOL    = 4;

  logic              clk;
  logic              rst;
  logic              start;
  logic [FRAC_W-1:0] x;
  logic              mode;
  logic              busy;
  logic              done;
  logic [INT_W-1:0]  intpart;
  logic [FRAC_W-1:0] fracpart;

  int     vectors;
  int     miscompares;
  longint prevRef;

  exponential_param #(
    .FRAC_W (FRAC_W),
    .INT_W  (INT_W),
    .TERMS  (TERMS),
    .GUARD  (GUARD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .x        (x),
    .mode     (mode),
    .busy     (busy),
    .done     (done),
    .intpart  (intpart),
    .fracpart (fracpart)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal result scaled to output LSBs, truncated toward zero.
  function automatic longint refScaled(input int xv, input bit m);
    real xr;
    real v;
    xr = real'(xv) / 65536.0;
    v  = m ? $exp(-xr) : $exp(xr);
    return longint'($floor(v * 65536.0));
  endfunction

  // Window for the exit index: the exact term x^k/k! in internal LSBs is
  // certainly non-zero after truncation while it is >= 8, and certainly
  // zero once below 1. Capped at the last configured index.
  function automatic void exitBounds(input int xv, output int lo, output int hi);
    real t;
    real xr;
    bit  loSet;
    bit  hiSet;
    xr    = real'(xv) / 65536.0;
    t     = real'(1 << (FRAC_W + GUARD));
    lo    = TERMS - 1;
    hi    = TERMS - 1;
    loSet = 1'b0;
    hiSet = 1'b0;
    for (int k = 1; k < TERMS; k++) begin
      t = t * xr / real'(k);
      if (!loSet && t < 8.0) begin
        lo    = k;
        loSet = 1'b1;
      end
      if (!hiSet && t < 1.0) begin
        hi    = k;
        hiSet = 1'b1;
      end
    end
  endfunction

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkNear(input string tag, input longint observed, input longint expected,
                           input longint tol);
    vectors++;
    assert ((observed - expected <= tol) && (expected - observed <= tol))
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d tol=%0d", tag, observed, expected, tol);
    end
  endtask

  task automatic checkRange(input string tag, input longint observed, input longint lo,
                            input longint hi);
    vectors++;
    assert ((observed >= lo) && (observed <= hi))
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d..%0d", tag, observed, lo, hi);
    end
  endtask

  // Waits (bounded) for done, sampling 1 time unit after each rising edge.
  // Optionally re-pulses start or scrambles x/mode while the unit is busy.
  task automatic waitDone(input bit rePulse, input bit wiggle, output int latency);
    latency = 0;
    while (done !== 1'b1 && latency < 40) begin
      if (latency == 1) begin
        checkOutput("busy_during_op", longint'(busy), 1);
        checkNear("hold_result", longint'({intpart, fracpart}), prevRef, TOL);
      end
      if (wiggle && latency == 3) begin
        x    = 16'($urandom);
        mode = ~mode;
      end
      if (rePulse && latency == 4) start = 1'b1;
      if (rePulse && latency == 5) start = 1'b0;
      @(posedge clk);
      #1;
      latency++;
    end
    checkOutput("done_reached", longint'(done), 1);
  endtask

  // Issues one request from IDLE and returns in the DONE cycle.
  task automatic applyStimulus(input int xv, input bit m, input bit rePulse, input bit wiggle,
                               output int latency);
    @(negedge clk);
    x     = 16'(xv);
    mode  = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(rePulse, wiggle, latency);
  endtask

  task automatic checkResult(input int xv, input bit m, input int latency);
    longint expRes;
    int     lo;
    int     hi;
    expRes = refScaled(xv, m);
    checkNear("result", longint'({intpart, fracpart}), expRes, TOL);
    checkOutput("latency_odd", longint'(latency % 2), 1);
    exitBounds(xv, lo, hi);
    checkRange("exit_index", longint'((latency - 1) / 2), lo, hi);
    prevRef = expRes;
  endtask

  task automatic finishPulse();
    @(posedge clk);
    #1;
    checkOutput("done_width", longint'(done), 0);
    checkOutput("idle_after_done", longint'(busy), 0);
  endtask

  initial begin
    int latency;
    int extraDones;
    int xv;
    bit m;

    vectors     = 0;
    miscompares = 0;
    prevRef     = 0;
    rst         = 1'b1;
    start       = 1'b0;
    x           = '0;
    mode        = 1'b0;

    // Reset state
    #12;
    checkOutput("reset_busy", longint'(busy), 0);
    checkOutput("reset_done", longint'(done), 0);
    checkOutput("reset_intpart", longint'(intpart), 0);
    checkOutput("reset_fracpart", longint'(fracpart), 0);
    @(negedge clk);
    rst = 1'b0;

    // e^(3080/65536): exact series term vanishes at k=4, so 9 cycles
    applyStimulus(3080, 1'b0, 1'b0, 1'b0, latency);
    checkResult(3080, 1'b0, latency);
    checkOutput("intpart_3080", longint'(intpart), 1);
    finishPulse();

    // Next request a few cycles later
    repeat (2) @(posedge clk);
    applyStimulus(2481, 1'b0, 1'b0, 1'b0, latency);
    checkResult(2481, 1'b0, latency);
    finishPulse();

    // e^-0.5
    applyStimulus(32768, 1'b1, 1'b0, 1'b0, latency);
    checkResult(32768, 1'b1, latency);
    checkOutput("intpart_neg_half", longint'(intpart), 0);
    finishPulse();

    // x = 0 exits right after the first term
    applyStimulus(0, 1'b0, 1'b0, 1'b0, latency);
    checkResult(0, 1'b0, latency);
    checkOutput("latency_zero_x", longint'(latency), 3);
    checkOutput("fracpart_zero_x", longint'(fracpart), 0);
    finishPulse();

    // Largest operand runs the full series; start re-pulsed while busy
    applyStimulus(65535, 1'b0, 1'b1, 1'b0, latency);
    checkResult(65535, 1'b0, latency);
    checkOutput("latency_full", longint'(latency), 2 * TERMS - 1);
    checkOutput("intpart_max_x", longint'(intpart), 2);
    finishPulse();
    extraDones = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) extraDones++;
    end
    checkOutput("extra_dones", longint'(extraDones), 0);

    // Operand and mode scrambled mid-operation must not matter
    applyStimulus(40000, 1'b1, 1'b0, 1'b1, latency);
    checkResult(40000, 1'b1, latency);

    // Still in the DONE cycle: start raised here is ignored, but held into
    // the following IDLE cycle it launches a new request.
    x     = 16'd12345;
    mode  = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("start_in_done_ignored", longint'(busy), 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("start_held_into_idle", longint'(busy), 1);
    waitDone(1'b0, 1'b0, latency);
    checkResult(12345, 1'b0, latency);
    finishPulse();

    // Reset in the middle of an operation
    @(negedge clk);
    x     = 16'd50000;
    mode  = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", longint'(busy), 0);
    checkOutput("midrst_done", longint'(done), 0);
    checkOutput("midrst_result", longint'({intpart, fracpart}), 0);
    prevRef    = 0;
    extraDones = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) extraDones++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (16) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) extraDones++;
    end
    checkOutput("midrst_no_done", longint'(extraDones), 0);

    applyStimulus(3080, 1'b0, 1'b0, 1'b0, latency);
    checkResult(3080, 1'b0, latency);
    finishPulse();

    // Randomized operands and modes
    for (int i = 0; i < 12; i++) begin
      xv = int'($urandom_range(0, 65535));
      m  = 1'($urandom_range(0, 1));
      applyStimulus(xv, m, 1'b0, 1'b0, latency);
      checkResult(xv, m, latency);
      finishPulse();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
